// File: rtl/aes_key_sched_ctrl.sv
// Control FSM for AES-128/192/256 key expansion: walks the expanded word index,
// tells the shared key datapath which operation to apply to each word, and
// arbitrates for the shared S-box with a req/ack handshake.
// Latency: one word per cycle when no S-box is needed, two when it is, plus one
// cycle per cycle sbox_ack is withheld. All outputs are registered.
// Backpressure: sbox_req is held until sbox_ack; load_key is ignored while busy.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   load_key, key_len   start request (sampled in IDLE); 0=128, 1=192, 2=256, 3=illegal
//   sbox_ack            S-box grant/result valid (may coincide with sbox_req)
//   busy, key_err       operation in progress / illegal-length pulse
//   word_we, word_idx,  datapath write strobe, word index i, operation
//   word_op, rcon       (COPY/XOR/ROT_SUB_RCON/SUB_ONLY) and round constant
//   sbox_req            S-box request
//   rk_valid, round_num round key complete (i mod 4 == 3), round number i>>2
//   expansion_done      one-cycle pulse in DONE
//   expand_cycles       cycle counter, present when KEYSCHED_PERF_CNT_EN is defined
module aes_key_sched_ctrl #(
  parameter int MAX_KEY_BITS = 256,
  parameter int WIDX_W       = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_key,
  input  logic [1:0]        key_len,
  input  logic              sbox_ack,
  output logic              busy,
  output logic              key_err,
  output logic              word_we,
  output logic [WIDX_W-1:0] word_idx,
  output logic [1:0]        word_op,
  output logic [7:0]        rcon,
  output logic              sbox_req,
  output logic              rk_valid,
  output logic [3:0]        round_num,
  output logic              expansion_done,
  output logic [7:0]        expand_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_XOR, S_DONE} state_t;

  localparam logic [1:0] OP_COPY    = 2'd0;
  localparam logic [1:0] OP_XOR     = 2'd1;
  localparam logic [1:0] OP_ROT     = 2'd2;
  localparam logic [1:0] OP_SUBONLY = 2'd3;

  state_t            state;
  logic [WIDX_W-1:0] k;        // i mod Nk, kept as a wrapping counter
  logic [WIDX_W-1:0] nk;       // Nk latched at acceptance
  logic [WIDX_W-1:0] nw_last;  // Nw-1 latched at acceptance

  logic [WIDX_W-1:0] nxt_i;
  logic [WIDX_W-1:0] nxt_k;
  logic              nxt_rot;
  logic              nxt_subonly;
  logic              nxt_rk;
  logic              key_ok;
  logic [7:0]        rcon_x2;

  always_comb begin
    nxt_i       = word_idx + 1'b1;
    nxt_k       = (k == nk - 1'b1) ? '0 : k + 1'b1;
    nxt_rot     = (nxt_k == '0);
    nxt_subonly = (nk == WIDX_W'(8)) && (nxt_k == WIDX_W'(4));
    nxt_rk      = (nxt_i[1:0] == 2'b11);
    // Key length in bits is 128 + 64*key_len; code 3 is never legal.
    key_ok      = (key_len != 2'd3) && ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);
    rcon_x2     = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      k              <= '0;
      nk             <= WIDX_W'(4);
      nw_last        <= '0;
      busy           <= 1'b0;
      key_err        <= 1'b0;
      word_we        <= 1'b0;
      word_idx       <= '0;
      word_op        <= OP_COPY;
      rcon           <= 8'h01;
      sbox_req       <= 1'b0;
      rk_valid       <= 1'b0;
      round_num      <= '0;
      expansion_done <= 1'b0;
    end else begin
      key_err        <= 1'b0;
      rk_valid       <= 1'b0;
      expansion_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_key) begin
            if (key_ok) begin
              state    <= S_LOAD;
              busy     <= 1'b1;
              word_we  <= 1'b1;
              word_op  <= OP_COPY;
              word_idx <= '0;
              k        <= '0;
              rcon     <= 8'h01;
              nk       <= WIDX_W'(4 + 2 * int'(key_len));
              nw_last  <= WIDX_W'(43 + 8 * int'(key_len));
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          word_idx <= nxt_i;
          if (word_idx == nk - 1'b1) begin
            // First derived word always has k == 0, so it needs RotWord+SubWord+Rcon.
            state    <= S_SUB;
            k        <= '0;
            word_we  <= 1'b0;
            sbox_req <= 1'b1;
            word_op  <= OP_ROT;
          end else begin
            rk_valid <= nxt_rk;
            if (nxt_rk) round_num <= 4'(nxt_i >> 2);
          end
        end
        S_SUB: begin
          if (sbox_ack) begin
            state    <= S_XOR;
            sbox_req <= 1'b0;
            word_we  <= 1'b1;
            rk_valid <= (word_idx[1:0] == 2'b11);
            if (word_idx[1:0] == 2'b11) round_num <= 4'(word_idx >> 2);
          end
        end
        S_XOR: begin
          // word_op still names the operation of the word being written here.
          if (word_op == OP_ROT) rcon <= rcon_x2;
          if (word_idx == nw_last) begin
            state          <= S_DONE;
            word_we        <= 1'b0;
            expansion_done <= 1'b1;
          end else begin
            word_idx <= nxt_i;
            k        <= nxt_k;
            if (nxt_rot || nxt_subonly) begin
              state    <= S_SUB;
              word_we  <= 1'b0;
              sbox_req <= 1'b1;
              word_op  <= nxt_rot ? OP_ROT : OP_SUBONLY;
            end else begin
              word_we  <= 1'b1;
              word_op  <= OP_XOR;
              rk_valid <= nxt_rk;
              if (nxt_rk) round_num <= 4'(nxt_i >> 2);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KEYSCHED_PERF_CNT_EN
  // Reads 1 in the first LOAD cycle and the full length in the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      expand_cycles <= '0;
    end else if (state == S_IDLE && load_key && key_ok) begin
      expand_cycles <= 8'd1;
    end else if ((state == S_LOAD || state == S_SUB || state == S_XOR) &&
                 expand_cycles != 8'hFF) begin
      expand_cycles <= expand_cycles + 1'b1;
    end
  end
`else
  assign expand_cycles = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, load_key = 1'b0, sbox_ack = 1'b0;
  logic [1:0] key_len = 2'd0;
  logic       busy, key_err, word_we, sbox_req, rk_valid, expansion_done;
  logic [5:0] word_idx;
  logic [1:0] word_op;
  logic [7:0] rcon, expand_cycles;
  logic [3:0] round_num;

  logic       load_key2 = 1'b0, sbox_ack2 = 1'b0;
  logic [1:0] key_len2 = 2'd0;
  logic       busy2, key_err2, word_we2, sbox_req2, rk_valid2, expansion_done2;
  logic [5:0] word_idx2;
  logic [1:0] word_op2;
  logic [7:0] rcon2, expand_cycles2;
  logic [3:0] round_num2;

  aes_key_sched_ctrl #(.MAX_KEY_BITS(256), .WIDX_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .load_key(load_key), .key_len(key_len), .sbox_ack(sbox_ack),
    .busy(busy), .key_err(key_err), .word_we(word_we), .word_idx(word_idx), .word_op(word_op),
    .rcon(rcon), .sbox_req(sbox_req), .rk_valid(rk_valid), .round_num(round_num),
    .expansion_done(expansion_done), .expand_cycles(expand_cycles));

  aes_key_sched_ctrl #(.MAX_KEY_BITS(128), .WIDX_W(6)) dut128 (
    .clk(clk), .reset_n(reset_n), .load_key(load_key2), .key_len(key_len2), .sbox_ack(sbox_ack2),
    .busy(busy2), .key_err(key_err2), .word_we(word_we2), .word_idx(word_idx2), .word_op(word_op2),
    .rcon(rcon2), .sbox_req(sbox_req2), .rk_valid(rk_valid2), .round_num(round_num2),
    .expansion_done(expansion_done2), .expand_cycles(expand_cycles2));

  typedef struct { int idx; int op; int rc; } wr_t;
  wr_t exp_wr[$];
  int  exp_done[$];
  int  exp_perf[$];
  int  exp_err[$];
  int  tests = 0, fails = 0;
  int  cyc = 0;
  int  ack_wait = 0;
  int  ack_n = 0;
  int  last_perf = 0;
  wr_t mon_e;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // S-box responder: ack arrives after ack_wait withheld cycles of each request.
  initial forever begin
    @(posedge clk); #1;
    if (!sbox_req) begin
      ack_n = 0; sbox_ack = 1'b0;
    end else begin
      sbox_ack = (ack_n >= ack_wait); ack_n++;
    end
  end

  function automatic int rcon_of(input int r);
    int t[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    return t[r];
  endfunction

  // Reference model: FIPS-197 schedule shape, one entry per expanded word.
  task automatic push_run(input int kl, input int w, output int t_total);
    int nk, nw, nsub;
    wr_t e;
    nk = 4 + 2 * kl;
    nw = 4 * (nk + 7);
    nsub = 0;
    for (int i = 0; i < nw; i++) begin
      e.idx = i; e.rc = -1;
      if (i < nk) e.op = 0;
      else if (i % nk == 0) begin e.op = 2; e.rc = rcon_of(i / nk - 1); nsub++; end
      else if (nk == 8 && i % nk == 4) begin e.op = 3; nsub++; end
      else e.op = 1;
      exp_wr.push_back(e);
    end
    t_total = nw + nsub * (1 + w);
  endtask

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (word_we) begin
      if (exp_wr.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: idx %0d with no write expected", word_idx);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_idx", word_idx, mon_e.idx);
        chk("wr_op", word_op, mon_e.op);
        chk("rk_valid", rk_valid, int'(mon_e.idx % 4 == 3));
        if (rk_valid) chk("round_num", round_num, mon_e.idx / 4);
      end
    end else if (rk_valid) begin
      tests++; fails++;
      $display("FAIL rk_valid_without_we: round_num %0d", round_num);
    end
    if (sbox_req) begin
      chk("req_we_excl", word_we, 0);
      if (exp_wr.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_sbox_req: idx %0d", word_idx);
      end else begin
        chk("sub_idx", word_idx, exp_wr[0].idx);
        chk("sub_op", word_op, exp_wr[0].op);
        if (exp_wr[0].rc >= 0) chk("sub_rcon", rcon, exp_wr[0].rc);
      end
    end
    if (expansion_done) begin
      if (exp_done.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        chk("done_cycle", cyc, exp_done.pop_front());
        chk("writes_left", exp_wr.size(), 0);
        chk("expand_cycles", expand_cycles, exp_perf.pop_front());
        chk("busy_in_done", busy, 1);
      end
    end
    if (key_err) begin
      if (exp_err.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_key_err at cycle %0d", cyc);
      end else void'(exp_err.pop_front());
    end
  end

  task automatic start(input int kl, input int w);
    int t_total;
    ack_wait = w;
    push_run(kl, w, t_total);
    @(posedge clk); #1;
    load_key = 1'b1; key_len = 2'(kl);
    exp_done.push_back(cyc + 1 + t_total);
`ifdef KEYSCHED_PERF_CNT_EN
    last_perf = (t_total + 1 > 255) ? 255 : t_total + 1;
`else
    last_perf = 0;
`endif
    exp_perf.push_back(last_perf);
    @(posedge clk); #1;
    load_key = 1'b0; key_len = 2'($urandom);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic run(input int kl, input int w, input bit poke);
    int n;
    start(kl, w);
    n = 0;
    while (exp_done.size() != 0 && n < 3000) begin
      @(posedge clk); #1; n++;
      if (poke && n == 17) begin load_key = 1'b1; key_len = 2'($urandom_range(0, 2)); end
      else load_key = 1'b0;
    end
    load_key = 1'b0;
    if (exp_done.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: key_len %0d, no expansion_done within %0d cycles", kl, n);
      exp_wr.delete(); exp_done.delete(); exp_perf.delete();
    end
    chk("busy_after_done", busy, 0);
    @(posedge clk); #1;
    chk("perf_hold", expand_cycles, last_perf);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rcon", rcon, 8'h01);
    chk("rst_word_we", word_we, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_perf", expand_cycles, 0);
    reset_n = 1'b1;

    run(0, 0, 1'b0);   // AES-128, ack tied to req
    run(2, 0, 1'b0);   // AES-256, zero-wait
    run(1, 2, 1'b0);   // AES-192, 3-cycle ack
    run(0, 0, 1'b1);   // load_key while busy

    // Illegal key_len on the 256-bit instance, too-long keys on the 128-bit one.
    @(posedge clk); #1;
    load_key = 1'b1; key_len = 2'd3; exp_err.push_back(1);
    load_key2 = 1'b1; key_len2 = 2'd2;
    @(posedge clk); #1;
    load_key = 1'b0; load_key2 = 1'b0;
    chk("key_err_pulse", key_err, 1);
    chk("key_err_128", key_err2, 1);
    @(posedge clk); #1;
    chk("key_err_clear", key_err, 0);
    chk("err_busy", busy, 0);
    chk("err_busy_128", busy2, 0);
    chk("err_seen", exp_err.size(), 0);
    load_key2 = 1'b1; key_len2 = 2'd1;
    @(posedge clk); #1;
    load_key2 = 1'b0;
    chk("key_err_192_on_128", key_err2, 1);
    chk("busy_192_on_128", busy2, 0);
    chk("we_192_on_128", word_we2, 0);

    for (int r = 0; r < 4; r++)
      run($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Reset in the middle of the SUB phase of word 20 (AES-256).
    begin
      int n;
      start(2, 3);
      n = 0;
      while (!(sbox_req && word_idx == 6'd20) && n < 500) begin @(posedge clk); #1; n++; end
      chk("reach_sub_i20", word_idx, 20);
      reset_n = 1'b0;
      exp_wr.delete(); exp_done.delete(); exp_perf.delete();
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_we", word_we, 0);
      chk("mid_rst_req", sbox_req, 0);
      chk("mid_rst_idx", word_idx, 0);
      chk("mid_rst_op", word_op, 0);
      chk("mid_rst_rcon", rcon, 8'h01);
      chk("mid_rst_round", round_num, 0);
      chk("mid_rst_perf", expand_cycles, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
    run(0, 1, 1'b0);   // restart from i=0, rcon=0x01

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
